// File: rtl/bp_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_cfg_loader_pkg
// Description : Shared register addresses, state encoding and write record
//               used by the boot-time configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_cfg_loader_pkg;

   // Per-core configuration register addresses
   localparam logic [15:0] cfg_reg_freeze_gp  = 16'h0001;
   localparam logic [15:0] cfg_reg_core_id_gp = 16'h0002;
   localparam logic [15:0] cfg_reg_did_gp     = 16'h0003;
   localparam logic [15:0] cfg_reg_npc_gp     = 16'h0004;

   // Field widths of the internal write record; ports are resized from these
   localparam int unsigned cfg_coord_width_gp = 4;
   localparam int unsigned cfg_addr_width_gp  = 16;
   localparam int unsigned cfg_data_width_gp  = 64;

   // Index of the last register written per core during the main pass
   localparam logic [1:0]  cfg_reg_last_gp    = 2'd3;

   typedef enum logic [2:0] {
      e_idle     = 3'd0,
      e_write    = 3'd1,
      e_unfreeze = 3'd2,
      e_drain    = 3'd3,
      e_done     = 3'd4
   } bp_cfg_loader_state_e;

   typedef struct packed {
      logic [cfg_coord_width_gp-1:0] x;
      logic [cfg_coord_width_gp-1:0] y;
      logic [cfg_addr_width_gp-1:0]  addr;
      logic [cfg_data_width_gp-1:0]  data;
   } bp_cfg_write_s;

   // Counter width helper: a single-entry range still needs one bit
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_cfg_credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_cfg_credit_counter
// Description : Saturating up/down credit counter. Starts full, decrements on
//               an issued write, increments on an ack. Flags an ack that would
//               push it beyond its maximum.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_cfg_credit_counter
   import bp_cfg_loader_pkg::*;
#(
   parameter  int unsigned max_credits_p = 4,
   localparam int unsigned width_lp      = safe_clog2(max_credits_p + 1)
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic dec_i,
   input  logic inc_i,
   output logic empty_o,
   output logic full_o,
   output logic empty_next_o
);

   localparam logic [width_lp-1:0] max_lp = width_lp'(max_credits_p);

   logic [width_lp-1:0] count_q;
   logic [width_lp-1:0] count_d;
   logic                overflow;

   // Next credit count; simultaneous inc and dec cancel, an ack at full saturates
   always_comb begin
      count_d  = count_q;
      overflow = inc_i & ~dec_i & (count_q == max_lp);
      if (inc_i && !dec_i && !overflow) begin
         count_d = count_q + width_lp'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - width_lp'(1);
      end
   end

   // Credit register, reset to the full allowance
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q <= max_lp;
      end else begin
         count_q <= count_d;
      end
   end

   assign empty_o      = (count_q == '0);
   assign full_o       = (count_q == max_lp);
   assign empty_next_o = (count_d == '0);

   a_no_credit_overflow: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) !overflow
   );

endmodule
`default_nettype wire

// File: rtl/bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : bp_cfg_loader
// Description : Boot-time configuration sequencer. Writes FREEZE, CORE_ID,
//               DID and NPC into every core tile, then clears FREEZE on every
//               core, throttled by a credit counter replenished by acks.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_cfg_loader
   import bp_cfg_loader_pkg::*;
#(
   parameter int unsigned cc_x_dim_p       = 1,
   parameter int unsigned cc_y_dim_p       = 1,
   parameter int unsigned y_offset_p       = 1,
   parameter int unsigned coord_width_p    = 4,
   parameter int unsigned cfg_addr_width_p = 16,
   parameter int unsigned cfg_data_width_p = 64,
   parameter int unsigned max_credits_p    = 4,
   parameter logic [63:0] boot_pc_p        = 64'h8000_0000,
   parameter int unsigned io_did_p         = 0
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        start_i,
   output logic                        cfg_v_o,
   input  logic                        cfg_ready_i,
   output logic [coord_width_p-1:0]    cfg_x_o,
   output logic [coord_width_p-1:0]    cfg_y_o,
   output logic [cfg_addr_width_p-1:0] cfg_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_data_o,
   input  logic                        cfg_ack_i,
   output logic                        busy_o,
   output logic                        done_o
);

   localparam int unsigned x_width_lp  = safe_clog2(cc_x_dim_p);
   localparam int unsigned y_width_lp  = safe_clog2(cc_y_dim_p);
   localparam int unsigned id_width_lp = safe_clog2(cc_x_dim_p * cc_y_dim_p);

   localparam logic [x_width_lp-1:0] x_last_lp = x_width_lp'(cc_x_dim_p - 1);
   localparam logic [y_width_lp-1:0] y_last_lp = y_width_lp'(cc_y_dim_p - 1);

   bp_cfg_loader_state_e   state_q,   state_d;
   logic [x_width_lp-1:0]  x_q,       x_d;
   logic [y_width_lp-1:0]  y_q,       y_d;
   logic [1:0]             reg_q,     reg_d;
   logic [id_width_lp-1:0] core_id_q, core_id_d;
   logic                   cfg_v_q,   cfg_v_d;
   logic                   busy_q,    busy_d;
   logic                   done_q,    done_d;
   bp_cfg_write_s          wr_q,      wr_d;

   logic xfer;
   logic credit_empty;
   logic credit_full;
   logic credit_empty_next;

   assign xfer = cfg_v_q & cfg_ready_i;

   bp_cfg_credit_counter #(
      .max_credits_p (max_credits_p)
   ) u_credits (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .dec_i        (xfer),
      .inc_i        (cfg_ack_i),
      .empty_o      (credit_empty),
      .full_o       (credit_full),
      .empty_next_o (credit_empty_next)
   );

   // Sequence pointer: reg fastest, then x, then y; moves only on a transfer.
   // core_id tracks y*cc_x_dim_p+x by counting cores as they are visited.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      reg_d     = reg_q;
      core_id_d = core_id_q;
      case (state_q)
         e_idle: begin
            if (start_i) begin
               state_d   = e_write;
               x_d       = '0;
               y_d       = '0;
               reg_d     = '0;
               core_id_d = '0;
            end
         end
         e_write: begin
            if (xfer) begin
               if (reg_q != cfg_reg_last_gp) begin
                  reg_d = reg_q + 2'd1;
               end else begin
                  reg_d = '0;
                  if (x_q != x_last_lp) begin
                     x_d       = x_q + x_width_lp'(1);
                     core_id_d = core_id_q + id_width_lp'(1);
                  end else begin
                     x_d = '0;
                     if (y_q != y_last_lp) begin
                        y_d       = y_q + y_width_lp'(1);
                        core_id_d = core_id_q + id_width_lp'(1);
                     end else begin
                        y_d     = '0;
                        state_d = e_unfreeze;
                     end
                  end
               end
            end
         end
         e_unfreeze: begin
            if (xfer) begin
               if (x_q != x_last_lp) begin
                  x_d = x_q + x_width_lp'(1);
               end else begin
                  x_d = '0;
                  if (y_q != y_last_lp) begin
                     y_d = y_q + y_width_lp'(1);
                  end else begin
                     y_d     = '0;
                     state_d = e_drain;
                  end
               end
            end
         end
         e_drain: begin
            if (credit_full) begin
               state_d = e_done;
            end
         end
         e_done: begin
            state_d = e_done;
         end
         default: begin
            state_d = e_idle;
         end
      endcase
   end

   // Next payload and status, derived from where the pointer will be so the
   // registered outputs line up with the registered pointer
   always_comb begin
      wr_d    = '0;
      cfg_v_d = 1'b0;
      busy_d  = (state_d == e_write) || (state_d == e_unfreeze) || (state_d == e_drain);
      done_d  = (state_d == e_done);
      if ((state_d == e_write) || (state_d == e_unfreeze)) begin
         cfg_v_d = !credit_empty_next;
         wr_d.x  = cfg_coord_width_gp'(x_d);
         wr_d.y  = cfg_coord_width_gp'(y_d) + cfg_coord_width_gp'(y_offset_p);
         if (state_d == e_unfreeze) begin
            wr_d.addr = cfg_reg_freeze_gp;
            wr_d.data = '0;
         end else begin
            case (reg_d)
               2'd0: begin
                  wr_d.addr = cfg_reg_freeze_gp;
                  wr_d.data = cfg_data_width_gp'(1);
               end
               2'd1: begin
                  wr_d.addr = cfg_reg_core_id_gp;
                  wr_d.data = cfg_data_width_gp'(core_id_d);
               end
               2'd2: begin
                  wr_d.addr = cfg_reg_did_gp;
                  wr_d.data = cfg_data_width_gp'(io_did_p);
               end
               default: begin
                  wr_d.addr = cfg_reg_npc_gp;
                  wr_d.data = cfg_data_width_gp'(boot_pc_p);
               end
            endcase
         end
      end
   end

   // State, pointer and registered outputs
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= e_idle;
         x_q       <= '0;
         y_q       <= '0;
         reg_q     <= '0;
         core_id_q <= '0;
         cfg_v_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_q      <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         reg_q     <= reg_d;
         core_id_q <= core_id_d;
         cfg_v_q   <= cfg_v_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_q      <= wr_d;
      end
   end

   // A raised valid always has a credit behind it, so it is never withdrawn
   a_valid_has_credit: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) cfg_v_q |-> !credit_empty
   );

   assign cfg_v_o    = cfg_v_q;
   assign cfg_x_o    = coord_width_p'(wr_q.x);
   assign cfg_y_o    = coord_width_p'(wr_q.y);
   assign cfg_addr_o = cfg_addr_width_p'(wr_q.addr);
   assign cfg_data_o = cfg_data_width_p'(wr_q.data);
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_cfg_loader
// Description : Self-checking bench for bp_cfg_loader. Instance 0 is a 2x2
//               array with 4 credits, instance 1 a 1x1 array with 2 credits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_cfg_loader;

   typedef struct packed {
      logic [3:0]  x;
      logic [3:0]  y;
      logic [15:0] addr;
      logic [63:0] data;
   } wr_t;

   localparam logic [63:0] BOOT_PC = 64'h8000_0000;
   localparam int          A_DID   = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  start_s, ready_s, ack_s;
   wire  [1:0]  v_s, busy_s, done_s;
   wire  [3:0]  x0, y0, x1, y1;
   wire  [15:0] addr0, addr1;
   wire  [63:0] data0, data1;

   int n_checks = 0;
   int n_fail   = 0;

   int  pend[2], nxfer[2], rmode[2], tick_no[2], first_x[2], last_x[2];
   bit  aack[2], stalled[2], done_seen[2];
   wr_t saved[2];
   wr_t log0[$], log1[$], exp_q[$];

   bp_cfg_loader #(
      .cc_x_dim_p(2), .cc_y_dim_p(2), .y_offset_p(1), .coord_width_p(4),
      .cfg_addr_width_p(16), .cfg_data_width_p(64), .max_credits_p(4),
      .boot_pc_p(BOOT_PC), .io_did_p(A_DID)
   ) u_a (
      .clk_i(clk), .reset_n_i(rst_n), .start_i(start_s[0]), .cfg_v_o(v_s[0]),
      .cfg_ready_i(ready_s[0]), .cfg_x_o(x0), .cfg_y_o(y0), .cfg_addr_o(addr0),
      .cfg_data_o(data0), .cfg_ack_i(ack_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0])
   );

   bp_cfg_loader #(
      .cc_x_dim_p(1), .cc_y_dim_p(1), .y_offset_p(1), .coord_width_p(4),
      .cfg_addr_width_p(16), .cfg_data_width_p(64), .max_credits_p(2),
      .boot_pc_p(BOOT_PC), .io_did_p(0)
   ) u_b (
      .clk_i(clk), .reset_n_i(rst_n), .start_i(start_s[1]), .cfg_v_o(v_s[1]),
      .cfg_ready_i(ready_s[1]), .cfg_x_o(x1), .cfg_y_o(y1), .cfg_addr_o(addr1),
      .cfg_data_o(data1), .cfg_ack_i(ack_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1])
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic wr_t cur(input int d);
      wr_t w;
      w.x    = (d == 0) ? x0 : x1;
      w.y    = (d == 0) ? y0 : y1;
      w.addr = (d == 0) ? addr0 : addr1;
      w.data = (d == 0) ? data0 : data1;
      return w;
   endfunction

   // Expected write stream straight from the register-set rules
   task automatic build_model(input int nx, input int ny, input int yoff, input int did);
      wr_t w;
      exp_q.delete();
      for (int y = 0; y < ny; y++)
         for (int x = 0; x < nx; x++)
            for (int r = 0; r < 4; r++) begin
               w.x    = 4'(x);
               w.y    = 4'(y + yoff);
               w.addr = 16'(r + 1);
               case (r)
                  0:       w.data = 64'd1;
                  1:       w.data = 64'(y * nx + x);
                  2:       w.data = 64'(did);
                  default: w.data = BOOT_PC;
               endcase
               exp_q.push_back(w);
            end
      for (int y = 0; y < ny; y++)
         for (int x = 0; x < nx; x++) begin
            w.x = 4'(x); w.y = 4'(y + yoff); w.addr = 16'h0001; w.data = 64'd0;
            exp_q.push_back(w);
         end
   endtask

   task automatic compare_log(input int d, input string name);
      wr_t got[$];
      if (d == 0) got = log0; else got = log1;
      check({name, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check(name, got[i], exp_q[i]);
   endtask

   // One clock of instance d: observe at negedge, drive just after posedge
   task automatic tick(input int d);
      wr_t w;
      @(negedge clk);
      w = cur(d);
      tick_no[d]++;
      if (stalled[d]) begin
         check("stall_valid_held", v_s[d], 1);
         check("stall_payload_stable", w, saved[d]);
      end
      if (done_s[d] && !done_seen[d]) begin
         done_seen[d] = 1;
         check("done_after_last_ack", pend[d] + int'(ack_s[d]), 0);
      end
      if (v_s[d] && ready_s[d]) begin
         if (d == 0) log0.push_back(w); else log1.push_back(w);
         if (nxfer[d] == 0) first_x[d] = tick_no[d];
         last_x[d] = tick_no[d];
         nxfer[d]++;
         if (aack[d]) pend[d]++;
      end
      stalled[d] = v_s[d] && !ready_s[d];
      saved[d]   = w;
      @(posedge clk);
      #1;
      start_s[d] = 1'b0;
      ready_s[d] = (rmode[d] == 2) ? 1'($urandom_range(0, 1)) : (rmode[d] == 1);
      ack_s[d]   = 1'b0;
      if (aack[d] && pend[d] > 0) begin
         ack_s[d] = 1'b1;
         pend[d]--;
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      start_s = '0;
      ready_s = '0;
      ack_s   = '0;
      for (int d = 0; d < 2; d++) begin
         pend[d] = 0; nxfer[d] = 0; stalled[d] = 0; done_seen[d] = 0; tick_no[d] = 0;
         first_x[d] = 0; last_x[d] = 0;
      end
      log0.delete();
      log1.delete();
      @(posedge clk);
      #1;
      check("reset_outputs_a", {v_s[0], busy_s[0], done_s[0], x0, y0, addr0, data0}, 0);
      check("reset_outputs_b", {v_s[1], busy_s[1], done_s[1], x1, y1, addr1, data1}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Start pulse; valid must be up in the cycle after start is sampled
   task automatic pulse_start(input int d);
      start_s[d] = 1'b1;
      ready_s[d] = 1'b0;
      @(posedge clk);
      #1;
      start_s[d] = 1'b0;
      @(negedge clk);
      check("first_valid_after_start", {v_s[d], busy_s[d]}, 2'b11);
      stalled[d] = 1;
      saved[d]   = cur(d);
   endtask

   task automatic run_until_done(input int d, input int budget);
      int n = 0;
      while (!done_s[d] && n < budget) begin
         tick(d);
         n++;
      end
      check("done_within_budget", done_s[d], 1);
      tick(d);
   endtask

   initial begin
      wr_t tbl[5];
      int  n;
      rmode[0] = 0; rmode[1] = 0; aack[0] = 0; aack[1] = 0;

      tbl[0] = {4'd0, 4'd1, 16'h0001, 64'h1};
      tbl[1] = {4'd0, 4'd1, 16'h0002, 64'h0};
      tbl[2] = {4'd0, 4'd1, 16'h0003, 64'h0};
      tbl[3] = {4'd0, 4'd1, 16'h0004, 64'h8000_0000};
      tbl[4] = {4'd0, 4'd1, 16'h0001, 64'h0};

      do_reset();

      // 1x1, ready high, ack one cycle after each transfer
      rmode[1] = 1; aack[1] = 1;
      pulse_start(1);
      run_until_done(1, 100);
      exp_q.delete();
      foreach (tbl[i]) exp_q.push_back(tbl[i]);
      compare_log(1, "t1_write");
      check("t1_back_to_back", last_x[1] - first_x[1], 4);
      check("t1_busy_clear_at_done", busy_s[1], 0);
      start_s[1] = 1'b1;
      repeat (8) tick(1);
      check("t1_start_after_done_ignored", nxfer[1], 5);
      check("t1_done_sticky", {done_s[1], v_s[1]}, 2'b10);

      // 2x2, random ready, stray start while busy
      rmode[0] = 2; aack[0] = 1;
      pulse_start(0);
      repeat (12) tick(0);
      start_s[0] = 1'b1;
      run_until_done(0, 2000);
      build_model(2, 2, 1, A_DID);
      compare_log(0, "t2_write");
      if (log0.size() > 13)
         check("t2_core11_id", log0[13], {4'd1, 4'd2, 16'h0002, 64'd3});

      // 2 credits, acks withheld then returned one at a time
      do_reset();
      rmode[1] = 1; aack[1] = 0;
      pulse_start(1);
      repeat (10) tick(1);
      check("t3_two_writes_no_ack", nxfer[1], 2);
      check("t3_valid_low_no_credit", v_s[1], 0);
      ack_s[1] = 1'b1;
      repeat (10) tick(1);
      check("t3_one_more_after_ack", nxfer[1], 3);
      ack_s[1] = 1'b1;
      repeat (4) tick(1);
      ack_s[1] = 1'b1;
      repeat (6) tick(1);
      check("t3_all_writes_issued", nxfer[1], 5);
      check("t3_drain_holds", {busy_s[1], done_s[1]}, 2'b10);
      ack_s[1] = 1'b1;
      repeat (5) tick(1);
      check("t3_drain_one_ack_short", done_s[1], 0);
      ack_s[1] = 1'b1;
      repeat (5) tick(1);
      check("t3_done_after_drain", {busy_s[1], done_s[1]}, 2'b01);
      build_model(1, 1, 1, 0);
      compare_log(1, "t3_write");

      // Asynchronous reset after write 7, then replay from the start
      do_reset();
      rmode[0] = 1; aack[0] = 1;
      pulse_start(0);
      n = 0;
      while (nxfer[0] < 7 && n < 100) begin
         tick(0);
         n++;
      end
      check("t4_reached_write7", nxfer[0], 7);
      #2 rst_n = 1'b0;
      #1;
      check("t4_async_reset_clears", {v_s[0], busy_s[0], done_s[0], x0, y0, addr0, data0}, 0);
      do_reset();
      rmode[0] = 2;
      pulse_start(0);
      run_until_done(0, 2000);
      build_model(2, 2, 1, A_DID);
      compare_log(0, "t4_replay");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
- Boot-time configuration sequencer for a parametrised core array (cc_x_dim_p × cc_y_dim_p tiles).
- After start_i, writes a fixed per-core register set into every core tile over a valid/ready config-write channel, then releases freeze on every core.
- Limits outstanding writes with a credit counter that is replenished by acks.
- Sits between the I/O complex and the coherence network; replaces hand-written per-config boot sequences.

Parameters:
- cc_x_dim_p, 1, core columns.
- cc_y_dim_p, 1, core rows.
- y_offset_p, 1, mesh row of the first core row (I/O row is below it).
- coord_width_p, 4, x/y coordinate width.
- cfg_addr_width_p, 16, config register address width.
- cfg_data_width_p, 64, config data width.
- max_credits_p, 4, maximum outstanding unacked writes (≥1).
- boot_pc_p, 64'h8000_0000, NPC value written to every core.
- io_did_p, 0, domain ID written to every core.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse; begins the sequence when idle.
- cfg_v_o  out  1  write valid.
- cfg_ready_i  in  1  sink accepts the write.
- cfg_x_o  out  coord_width_p  destination x.
- cfg_y_o  out  coord_width_p  destination y.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  register data.
- cfg_ack_i  in  1  one write completed (one credit returned).
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence complete; sticky until reset.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counters=0, credits=max_credits_p, cfg_v_o=0, busy_o=0, done_o=0. All data outputs are 0.
- States and transitions:
  - IDLE: on start_i go to WRITE with core (x,y)=(0,0) and reg=0.
  - WRITE: issues 4 writes per core. Iteration order is reg fastest, then x, then y. After the last reg of the last core, go to UNFREEZE at (0,0).
  - UNFREEZE: issues one write per core (x fastest). After the last core, go to DRAIN.
  - DRAIN: wait until credits==max_credits_p, then go to DONE.
  - DONE: terminal; done_o=1; start_i is ignored.
- Register sequence per core, with addresses from the package:
  - reg0: FREEZE ← 1.
  - reg1: CORE_ID ← y*cc_x_dim_p+x. Computed by an accumulator, not a multiplier; zero-extended.
  - reg2: DID ← io_did_p.
  - reg3: NPC ← boot_pc_p.
  - UNFREEZE pass: FREEZE ← 0.
- Destination coordinates: cfg_x_o=x; cfg_y_o=y+y_offset_p.
- cfg_v_o is asserted in WRITE/UNFREEZE only when credits>0.
- Handshake:
  - A transfer occurs when cfg_v_o & cfg_ready_i.
  - Once cfg_v_o rises, it and all payload bits hold stable until the transfer. Credits cannot drop while a write is pending, so valid is never withdrawn.
  - Counters advance only on a transfer.
- Credits:
  - Transfer without ack: credits−1. Ack without transfer: credits+1. Both in the same cycle: unchanged.
  - Ack when credits==max_credits_p is an error: assertion fires and credits saturate.
- Timing: outputs are registered-state driven; the first cfg_v_o appears in the cycle after start_i is sampled.
- busy_o=1 in WRITE, UNFREEZE and DRAIN.
- start_i while busy or done: ignored.
- Write count: a full run issues exactly 5·N writes, where N=cc_x_dim_p·cc_y_dim_p.
- Counter widths: clog2 with a minimum of 1, so N=1 is legal.

Decomposition:
- Shared package bp_cfg_loader_pkg:
  - Address constants: cfg_reg_freeze_gp=16'h0001, cfg_reg_core_id_gp=16'h0002, cfg_reg_did_gp=16'h0003, cfg_reg_npc_gp=16'h0004.
  - State enum bp_cfg_loader_state_e.
  - Packed write struct bp_cfg_write_s {x, y, addr, data}.
- One sub-module: bp_cfg_credit_counter (up/down saturating counter with empty/full flags and the overflow assertion).

Test Plan:
- 1×1, ready tied 1, ack one cycle after each transfer → 5 writes: addr 1/2/3/4 with data 1/0/io_did_p/8000_0000, then addr 1 data 0, all at (0,1). done_o rises once the last ack is back.
- 2×2, ready random 50% → 20 writes in order. Core (1,1) gets CORE_ID=3 at y=2. Payload is stable during every stall; no dropped or duplicated writes.
- max_credits_p=2, acks withheld → exactly 2 transfers, then cfg_v_o=0. One ack → exactly one more write. DRAIN holds done_o=0 until 2 acks return.
- Simultaneous transfer+ack every cycle with credits=1 → credits stay at 1 and throughput is 1 write/cycle.
- reset_n_i asserted mid-WRITE (e.g. after write 7) → outputs clear immediately. A new start_i replays from core (0,0) reg0.
- start_i during busy and after done → no effect on sequence or counts; stray ack in IDLE with full credits → assertion fires.
